uart_rx: RTL
============

# uart_rx

UART receiver for the custom-UART FSM layer: recovers 8N1 frames (idle-high line, start bit 0, 8 data bits LSB first, stop bit 1) from the serial line the `Tx` block drives. It samples the line on an oversampled enable tick from the shared baud generator and validates the start bit at mid-bit. Each good byte is presented with a one-clock `valid` pulse; a bad stop bit raises a one-clock `frame_err` pulse. It sits between the pin (via an internal synchronizer) and the byte consumer.

## Interface
- `OVERSAMPLE`, 16: `ena` ticks per bit period; even, ≥4.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  oversample tick, one `clk` wide, `OVERSAMPLE`× baud rate.
- `in`  in  1  asynchronous serial line, idle high.
- `data`  out  8  last correctly received byte; held until the next good frame.
- `valid`  out  1  one-`clk` pulse when `data` is updated.
- `frame_err`  out  1  one-`clk` pulse when the stop-bit sample is 0.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- `in` passes through a 2-flop synchronizer every `clk` (not gated by `ena`), giving `in_s`. Synchronizer flops reset to 1.
- Counters: `tick_cnt` (width clog2(`OVERSAMPLE`)), `bit_cnt` (3 bits), 8-bit shift register. FSM and counters advance only on cycles with `ena`=1; with `ena`=0 all state holds.
- IDLE: if `in_s`=0 → START, `tick_cnt`←0.
- START: if `tick_cnt`=`OVERSAMPLE`/2−1: `in_s`=0 → DATA, `tick_cnt`←0, `bit_cnt`←0; `in_s`=1 → IDLE (glitch, no flag). Otherwise `tick_cnt`++.
- DATA: if `tick_cnt`=`OVERSAMPLE`−1: store `in_s` at shift position `bit_cnt`, `tick_cnt`←0; if `bit_cnt`=7 → STOP, else `bit_cnt`++. Otherwise `tick_cnt`++.
- STOP: if `tick_cnt`=`OVERSAMPLE`−1: `in_s`=1 → `data`←shift, `valid`←1, → IDLE; `in_s`=0 → `frame_err`←1, `data` unchanged, → BREAK. Otherwise `tick_cnt`++.
- BREAK: wait for an `ena` cycle with `in_s`=1 → IDLE. Prevents a held-low line (break) from re-triggering frames.
- `valid` and `frame_err` default to 0 on every `clk` not explicitly setting them; they are never high together.
- `busy` is 0 in IDLE and 1 in START, DATA, STOP and BREAK.
- Unreachable state encodings → IDLE on the next `ena` cycle.

## Timing
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0, state IDLE, counters 0. `rst` mid-frame aborts immediately: no `valid`/`frame_err` for the partial frame, and `data` is cleared to 0x00.
- Synchronizer latency: 2 `clk` from `in` to `in_s`.
- Let T0 be the `ena` cycle on which IDLE sees `in_s`=0. The start check occurs at T0+`OVERSAMPLE`/2. Data bit n (n=0..7) is sampled at T0+`OVERSAMPLE`/2+`OVERSAMPLE`·(n+1). The stop bit is sampled at T0+`OVERSAMPLE`/2+9·`OVERSAMPLE`; with the default this is T0+152.
- `valid`/`frame_err` are registered: high for the single `clk` after the edge of the stop-sample cycle. `busy` falls on the same edge (good frame).
- Back-to-back: the next start bit may be detected on the first `ena` cycle after returning to IDLE. A stop bit of exactly one bit period is sufficient.
- Glitch shorter than `OVERSAMPLE`/2 ticks: returns to IDLE at the check tick, with no output pulse.

## Test plan
- Reset: hold `rst` 2 cycles with `in`=1 → `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0.
- Single frame, `ena` every clk, 0xA5 LSB first, 16 ticks/bit → exactly one `valid` pulse at T0+152 (+1 clk), `data`=0xA5, `frame_err` never high, `busy` falls with `valid`.
- Back-to-back 0x00 then 0xFF, stop bits exactly 16 ticks, `ena` every 4th clk → two `valid` pulses 160 ticks apart, `data` 0x00 then 0xFF.
- Glitch: `in` low for 3 ticks then high → no `valid`/`frame_err`, `busy` high then low at tick T0+8, FSM back in IDLE.
- Framing error after a good 0xFF: send 0x3C with the stop bit low, hold low 40 ticks, then high → one `frame_err` pulse, `data` stays 0xFF, `busy` high until `in_s` returns to 1, no `valid`. A following 0x81 frame is received correctly.
- Reset mid-frame: assert `rst` one cycle after data bit 3 of 0x5A → `busy`=0, `data`=0x00, no pulses. Resend 0x5A → `valid` with `data`=0x5A.

Source files
------------

// File: rtl/uart_rx_if.sv
// Byte-side bundle of the UART receiver.
// The consumer/driver side (master) supplies the oversample tick and the
// serial line; the receiver side (slave) returns the recovered byte and
// its status pulses.
interface uart_rx_if;
    logic       ena;        // oversample tick, one clk wide
    logic       in;         // asynchronous serial line, idle high
    logic [7:0] data;       // last correctly received byte
    logic       valid;      // one-clk pulse when data updates
    logic       frame_err;  // one-clk pulse on a low stop bit
    logic       busy;       // receiver not idle

    modport master (
        output ena,
        output in,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  ena,
        input  in,
        output data,
        output valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// The line is synchronized every clk, then an FSM advancing only on
// oversample ticks validates the start bit at mid-bit, samples eight data
// bits LSB first one bit period apart and checks the stop bit. A good frame
// updates data with a one-clk valid pulse; a low stop bit gives a one-clk
// frame_err pulse and parks the FSM until the line returns high.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave rx
);

    localparam int TW          = $clog2(OVERSAMPLE);
    localparam int SYNC_STAGES = 2;

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // Synchronizer chain; element SYNC_STAGES-1 is the usable line sample.
    logic sync_reg [SYNC_STAGES];
    logic in_s;

    state_t        state_reg;
    logic [TW-1:0] tick_cnt_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic [7:0]    data_reg;
    logic          valid_reg;
    logic          frame_err_reg;

    // Metastability chain on the raw pin, free-running (not gated by ena)
    // and reset to the idle level so a reset never looks like a start bit.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            // First stage captures the asynchronous pin.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b1;
                end else begin
                    sync_reg[gi] <= rx.in;
                end
            end
        end else begin : g_rest
            // Later stages re-time the previous stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b1;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    end

    assign in_s = sync_reg[SYNC_STAGES-1];

    // Frame FSM with its counters, shift register and registered outputs.
    // Pulses default low every clk; everything else only moves on ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            tick_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            if (rx.ena) begin
                case (state_reg)
                    S_IDLE: begin
                        if (!in_s) begin
                            state_reg    <= S_START;
                            tick_cnt_reg <= '0;
                        end
                    end
                    S_START: begin
                        // Half a bit in: still low means a real start bit,
                        // high means it was a glitch and is dropped silently.
                        if (tick_cnt_reg == HALF_LAST) begin
                            if (!in_s) begin
                                state_reg    <= S_DATA;
                                tick_cnt_reg <= '0;
                                bit_cnt_reg  <= '0;
                            end else begin
                                state_reg <= S_IDLE;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TW'(1);
                        end
                    end
                    S_DATA: begin
                        // Mid-bit sampling: a full period after the
                        // start-bit centre lands on each data bit centre.
                        if (tick_cnt_reg == FULL_LAST) begin
                            shift_reg[bit_cnt_reg] <= in_s;
                            tick_cnt_reg           <= '0;
                            if (bit_cnt_reg == LAST_BIT) begin
                                state_reg <= S_STOP;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TW'(1);
                        end
                    end
                    S_STOP: begin
                        if (tick_cnt_reg == FULL_LAST) begin
                            tick_cnt_reg <= '0;
                            if (in_s) begin
                                data_reg  <= shift_reg;
                                valid_reg <= 1'b1;
                                state_reg <= S_IDLE;
                            end else begin
                                // Keep the previous good byte on a bad frame.
                                frame_err_reg <= 1'b1;
                                state_reg     <= S_BREAK;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TW'(1);
                        end
                    end
                    S_BREAK: begin
                        // A line held low must go high before a new frame.
                        if (in_s) begin
                            state_reg <= S_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rx.data      = data_reg;
    assign rx.valid     = valid_reg;
    assign rx.frame_err = frame_err_reg;
    assign rx.busy      = (state_reg != S_IDLE);

endmodule
